// File: rtl/px_stream_router.sv
// Routes pixel strobes from one of N_SRC sources through an elastic FIFO to the core,
// switching source only once the FIFO has drained. Optional macro: PX_ROUTER_STATS_EN.
module px_stream_router #(
    parameter int unsigned PX_WIDTH   = 24,
    parameter int unsigned N_SRC      = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SEL_W      = $clog2(N_SRC)
) (
    input  logic                      clk_i,
    input  logic                      nreset_i,
    input  logic [SEL_W-1:0]          sel_i,
    input  logic                      clear_i,
    input  logic [N_SRC-1:0]          src_rdy_i,
    input  logic [N_SRC*PX_WIDTH-1:0] src_px_i,
    input  logic                      core_busy_i,
    output logic                      core_rdy_o,
    output logic [PX_WIDTH-1:0]       core_px_o,
    output logic [SEL_W-1:0]          active_sel_o,
    output logic                      busy_o,
    output logic                      ovf_o,
    output logic [7:0]                drop_cnt_o,
    output logic [15:0]               px_cnt_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t              r_state;
    logic [SEL_W-1:0]    r_active_sel;
    logic [PX_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wptr;
    logic [PTR_W-1:0]    r_rptr;
    logic [CNT_W-1:0]    r_count;
    logic                r_core_rdy;
    logic [PX_WIDTH-1:0] r_core_px;
    logic                r_busy;
    logic                r_ovf;
    logic [7:0]          r_drop_cnt;

    logic                w_rdy;
    logic [PX_WIDTH-1:0] w_px;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    logic                w_drain_nxt;
    logic [CNT_W-1:0]    w_count_nxt;

    // Active-source mux; an out-of-range select matches nothing and yields no strobe.
    always_comb begin
        w_rdy = 1'b0;
        w_px  = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (SEL_W'(k) == r_active_sel) begin
                w_rdy = src_rdy_i[k];
                w_px  = src_px_i[k*PX_WIDTH +: PX_WIDTH];
            end
        end
    end

    always_comb begin
        w_full      = (r_count == CNT_W'(FIFO_DEPTH));
        w_empty     = (r_count == '0);
        w_pop       = !w_empty && !core_busy_i;
        w_push      = (r_state == ST_RUN) && w_rdy && (!w_full || w_pop);
        w_drop      = w_rdy && ((r_state == ST_DRAIN) || (w_full && !w_pop));
        w_drain_nxt = (r_state == ST_RUN) ? (sel_i != r_active_sel) : !w_empty;
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_state      <= ST_RUN;
            r_active_sel <= '0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_core_rdy   <= 1'b0;
            r_core_px    <= '0;
            r_busy       <= 1'b0;
            r_ovf        <= 1'b0;
            r_drop_cnt   <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_count    <= w_count_nxt;
            r_core_rdy <= w_pop;
            r_busy     <= w_drain_nxt || (w_count_nxt != '0);
            r_state    <= w_drain_nxt ? ST_DRAIN : ST_RUN;
            if (r_state == ST_DRAIN && w_empty) begin
                r_active_sel <= sel_i;
            end
            if (w_push) begin
                r_mem[r_wptr] <= w_px;
                r_wptr        <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_core_px <= r_mem[r_rptr];
                r_rptr    <= r_rptr + PTR_W'(1);
            end
            // Clear wins over a same-cycle drop.
            if (clear_i) begin
                r_ovf      <= 1'b0;
                r_drop_cnt <= '0;
            end else if (w_drop) begin
                r_ovf <= 1'b1;
                if (r_drop_cnt != 8'hFF) begin
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                end
            end
        end
    end

`ifdef PX_ROUTER_STATS_EN
    logic [15:0] r_px_cnt;

    // Delivered-pixel counter, wraps at 16 bits.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_px_cnt <= '0;
        end else if (clear_i) begin
            r_px_cnt <= '0;
        end else if (w_pop) begin
            r_px_cnt <= r_px_cnt + 16'd1;
        end
    end

    assign px_cnt_o = r_px_cnt;
`else
    assign px_cnt_o = 16'd0;
`endif

    assign core_rdy_o   = r_core_rdy;
    assign core_px_o    = r_core_px;
    assign active_sel_o = r_active_sel;
    assign busy_o       = r_busy;
    assign ovf_o        = r_ovf;
    assign drop_cnt_o   = r_drop_cnt;

endmodule

// File: doc/px_stream_router.md
Name: px_stream_router

Overview:
- Parametrised successor to the fixed SPI/LFSR pixel steering in the top level.
- Routes pixel strobes from N_SRC selectable sources (SPI, LFSR, future generators) into the processing core through a small elastic FIFO.
- Switches sources only after the FIFO drains, so pixels from two sources never interleave.
- Counts dropped pixels and flags overflow, so firmware can see stream loss that the current strobe-only path hides.

Parameters:
- PX_WIDTH, 24, pixel width in bits.
- N_SRC, 2, number of pixel sources; must be at least 2.
- FIFO_DEPTH, 4, FIFO entries; power of two, at least 2.
- SEL_W, $clog2(N_SRC), width of the source select.

Ports:
- clk_i  in  1  clock.
- nreset_i  in  1  reset; asynchronous assert, active-low.
- sel_i  in  SEL_W  requested source index; already synchronised by the caller.
- clear_i  in  1  synchronous clear of ovf_o, drop_cnt_o and px_cnt_o.
- src_rdy_i  in  N_SRC  per-source one-cycle pixel strobe.
- src_px_i  in  N_SRC*PX_WIDTH  packed source pixels; source k occupies bits [k*PX_WIDTH +: PX_WIDTH].
- core_busy_i  in  1  core cannot accept a pixel this cycle.
- core_rdy_o  out  1  one-cycle strobe; core_px_o is valid.
- core_px_o  out  PX_WIDTH  pixel to the core, registered.
- active_sel_o  out  SEL_W  source currently routed.
- busy_o  out  1  high in DRAIN state or when the FIFO is non-empty.
- ovf_o  out  1  sticky overflow flag.
- drop_cnt_o  out  8  saturating count of dropped pixels.
- px_cnt_o  out  16  count of delivered pixels; optional feature only.

Behaviour:
- Reset (nreset_i low, asynchronous) drives all outputs and internal state to 0:
  - FIFO count and read/write pointers cleared.
  - active_sel set to 0, state set to RUN.
- State RUN:
  - A push happens when src_rdy_i[active_sel] is high and the FIFO is not full.
  - Strobes from non-selected sources are ignored and are not counted as drops.
- State RUN, FIFO full:
  - A push with a simultaneous pop is accepted; count is unchanged.
  - A push without a pop is dropped: ovf_o <= 1 and drop_cnt_o increments.
- Pop rule:
  - A pop happens when count > 0 and core_busy_i is low.
  - On that edge, core_px_o <= head and core_rdy_o <= 1.
  - Otherwise core_rdy_o <= 0 and core_px_o holds its value.
  - At most one pop per cycle.
- Latency: a strobe in cycle c into an empty FIFO, with core_busy_i low, gives core_rdy_o high in cycle c+2.
- Throughput: one pixel per cycle sustained.
- Transition RUN -> DRAIN: taken when sel_i != active_sel.
- State DRAIN:
  - No pushes are accepted.
  - Strobes from the old active source count as drops and set ovf_o.
  - Pops continue normally.
- Transition DRAIN -> RUN: taken on the edge where count == 0.
  - active_sel <= sel_i, sampled on that edge.
  - If sel_i returns to the old value before the FIFO empties, the block still waits for empty and then reloads active_sel.
- sel_i out of range (>= N_SRC): treated as no source. RUN with no pushes; no drops counted.
- Saturation: drop_cnt_o saturates at 255; px_cnt_o wraps at 65535.
- clear_i:
  - Takes priority over increments in the same cycle.
  - Does not flush the FIFO or change state.
- Pointer arithmetic: pointers are modulo FIFO_DEPTH; count is a separate register of width $clog2(FIFO_DEPTH)+1.

Optional Feature:
- Macro: PX_ROUTER_STATS_EN.
- Defined: px_cnt_o increments on every core_rdy_o pulse and is cleared by clear_i.
- Undefined: px_cnt_o is tied to 0 and the counter flops are not instantiated.
- The port exists in both builds.

Test Plan:
- Reset mid-stream: 3 pixels queued, nreset_i pulsed low -> all outputs 0 immediately; FIFO empty after release.
- Source 0 strobes 0x123456 at cycle 10, core_busy_i low -> core_rdy_o high in cycle 12 only, core_px_o = 0x123456.
- core_busy_i high, 6 strobes with FIFO_DEPTH=4 -> 4 stored, ovf_o = 1, drop_cnt_o = 2; release busy -> 4 pulses on consecutive cycles, data in order.
- FIFO full, push and pop in the same cycle -> no drop, count stays 4.
- 2 pixels queued, sel_i 0->1 -> busy_o high; source 0 strobe during DRAIN -> drop_cnt_o +1; active_sel_o = 1 on the edge the FIFO empties; source 1 pixel delivered next.
- PX_ROUTER_STATS_EN defined, 300 pixels delivered, then 300 strobes dropped with core_busy_i held high -> px_cnt_o = 300, drop_cnt_o = 255; clear_i pulse -> px_cnt_o, drop_cnt_o and ovf_o all 0.
